// File: rtl/arbiter_rr_vh.sv
// rtl/arbiter_rr_vh.sv - registered fixed-priority / round-robin arbiter with hold timeout
module arbiter_rr_vh #(
    parameter int NUM_REQ  = 10,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               timeout
);

    localparam int HOLD_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    last, last_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic                timeout_nxt;

    logic                owner_req;
    logic                hold_exp;
    logic                rel;
    logic                exp_rel;
    logic [NUM_REQ-1:0]  arb_req;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    int                  d;
    int                  best_d;

    assign owner_req = |(req & grant);
    assign hold_exp  = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(HOLD_LAST_I));
    assign rel       = done | ~owner_req | hold_exp;
    // Expiry only counts as the cause when the owner neither finished nor dropped its request.
    assign exp_rel   = hold_exp & ~done & owner_req;
    assign arb_req   = (state == BUSY && exp_rel) ? (req & ~grant) : req;

    // Smallest distance wins; RR distance counts downward from last and wraps modulo NUM_REQ.
    always_comb begin
        d       = 0;
        best_d  = NUM_REQ + 1;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_req[i]) begin
                if (RR_MODE == 0)
                    d = NUM_REQ - i;
                else if (int'(last) > i)
                    d = int'(last) - i;
                else
                    d = int'(last) + NUM_REQ - i;
                if (d < best_d) begin
                    best_d  = d;
                    win_idx = IDX_W'(i);
                end
            end
        end
        win_found = |arb_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            last        <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_idx   <= idx_nxt;
            timeout     <= timeout_nxt;
            last        <= last_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = BUSY;
            BUSY:    if (rel && !win_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        last_nxt    = last;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        if (state == IDLE) begin
            if (win_found) begin
                grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                idx_nxt   = win_idx;
                last_nxt  = win_idx;
                hold_nxt  = '0;
            end
        end else if (rel) begin
            timeout_nxt = exp_rel;
            hold_nxt    = '0;
            if (win_found) begin
                grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                idx_nxt   = win_idx;
                last_nxt  = win_idx;
            end else begin
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        end else begin
            hold_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_vh.sv
// tb/tb_arbiter_rr_vh.sv - directed bench for arbiter_rr_vh in fixed-priority and round-robin modes
module tb_arbiter_rr_vh;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] req;
    logic       done;

    logic [9:0] fp_grant, rr_grant;
    logic       fp_valid, rr_valid;
    logic [3:0] fp_idx, rr_idx;
    logic       fp_timeout, rr_timeout;

    int tests_run = 0;
    int tests_failed = 0;
    logic [9:0] e;

    always #5 clk = ~clk;

    arbiter_rr_vh #(.NUM_REQ(10), .RR_MODE(0), .MAX_HOLD(4)) u_fp (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(fp_grant), .grant_valid(fp_valid), .grant_idx(fp_idx), .timeout(fp_timeout)
    );

    arbiter_rr_vh #(.NUM_REQ(10), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(rr_grant), .grant_valid(rr_valid), .grant_idx(rr_idx), .timeout(rr_timeout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        tick(); tick(); tick();
        chk("rst_grant", 16'(rr_grant), 16'h000);
        chk("rst_valid", 16'(rr_valid), 16'h0);
        chk("rst_idx", 16'(rr_idx), 16'h0);
        chk("rst_timeout", 16'(rr_timeout), 16'h0);
        chk("rst_fp_grant", 16'(fp_grant), 16'h000);
        rst = 1'b0;
        tick();
        chk("idle_grant", 16'(rr_grant), 16'h000);
        req = 10'h001;
        tick();
        chk("first_grant", 16'(rr_grant), 16'h001);
        chk("first_valid", 16'(rr_valid), 16'h1);
        chk("first_idx", 16'(rr_idx), 16'h0);

        // Fixed priority stays on 0x200; round-robin walks down and wraps.
        do_reset();
        req  = 10'h3FF;
        done = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            e = 10'd1 << (9 - (i % 10));
            chk("fp_hold_top", 16'(fp_grant), 16'h200);
            chk("rr_seq", 16'(rr_grant), 16'(e));
            chk("rr_seq_idx", 16'(rr_idx), 16'(9 - (i % 10)));
            chk("rr_seq_valid", 16'(rr_valid), 16'h1);
        end

        // Hold expiry alternates between requesters 4 and 2.
        do_reset();
        req = 10'h014;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("to_hold_a", 16'(rr_grant), 16'h010);
            chk("to_hold_a_pulse", 16'(rr_timeout), 16'h0);
        end
        tick();
        chk("to_rot_b", 16'(rr_grant), 16'h004);
        chk("to_rot_b_pulse", 16'(rr_timeout), 16'h1);
        chk("to_rot_b_fp", 16'(fp_grant), 16'h004);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("to_hold_b", 16'(rr_grant), 16'h004);
            chk("to_hold_b_pulse", 16'(rr_timeout), 16'h0);
        end
        tick();
        chk("to_rot_a", 16'(rr_grant), 16'h010);
        chk("to_rot_a_pulse", 16'(rr_timeout), 16'h1);

        // done coinciding with expiry is a plain release: no timeout pulse.
        do_reset();
        req = 10'h014;
        tick(); tick(); tick(); tick();
        chk("dt_pre", 16'(rr_grant), 16'h010);
        done = 1'b1;
        tick();
        chk("dt_grant", 16'(rr_grant), 16'h004);
        chk("dt_pulse", 16'(rr_timeout), 16'h0);
        done = 1'b0;

        // Owner drops its request; a non-owner change beforehand must not disturb.
        do_reset();
        req = 10'h010;
        tick();
        chk("drop_own", 16'(rr_grant), 16'h010);
        req = 10'h030;
        tick();
        chk("drop_nonowner", 16'(rr_grant), 16'h010);
        req = 10'h020;
        tick();
        chk("drop_grant", 16'(rr_grant), 16'h020);
        chk("drop_pulse", 16'(rr_timeout), 16'h0);

        // Reset mid-grant clears outputs and the round-robin pointer.
        do_reset();
        req = 10'h080;
        tick();
        chk("mid_own", 16'(rr_grant), 16'h080);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", 16'(rr_grant), 16'h000);
        chk("mid_rst_valid", 16'(rr_valid), 16'h0);
        chk("mid_rst_idx", 16'(rr_idx), 16'h0);
        rst  = 1'b0;
        req  = 10'h3FF;
        done = 1'b1;
        tick();
        chk("mid_restart", 16'(rr_grant), 16'h200);
        tick();
        chk("mid_next", 16'(rr_grant), 16'h100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
